// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register chain: skid-stage state
// encoding and occupancy counter width.
package pipe_reg_pkg;

  typedef logic [1:0] stage_st_t;

  localparam stage_st_t ST_EMPTY = 2'b00;
  localparam stage_st_t ST_BUSY  = 2'b01;
  localparam stage_st_t ST_FULL  = 2'b10;

  // Width able to hold 0..2*depth stored items.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_if.sv
// Valid/ready handshake bundle for the elastic register chain, including the
// synchronous flush. slave = the chain, master = the surrounding pipeline.
interface pipe_reg_elastic_if #(
  parameter int WIDTH = 32
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// One 2-entry skid stage (main reg M, skid reg S) with synchronous flush.
// All outputs come from registers. PIPE_REG_STATS_EN adds the occupancy output.
module pipe_skid_stage
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
`ifdef PIPE_REG_STATS_EN
  output logic [1:0]       occ_o,
`endif
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  stage_st_t        st_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;
  logic             in_fire;
  logic             out_fire;

  assign in_ready_o  = (st_q != ST_FULL);
  assign out_valid_o = (st_q != ST_EMPTY);
  assign out_data_o  = m_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  // Flush only clears state; M/S keep stale data that is never exposed as valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q <= ST_EMPTY;
      m_q  <= '0;
      s_q  <= '0;
    end else if (flush_i) begin
      st_q <= ST_EMPTY;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          if (in_fire) begin
            st_q <= ST_BUSY;
            m_q  <= in_data_i;
          end
        end
        ST_BUSY: begin
          case ({in_fire, out_fire})
            2'b10: begin
              st_q <= ST_FULL;
              s_q  <= in_data_i;
            end
            2'b01: st_q <= ST_EMPTY;
            2'b11: m_q  <= in_data_i;
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            st_q <= ST_BUSY;
            m_q  <= s_q;
          end
        end
        default: st_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_REG_STATS_EN
  assign occ_o = (st_q == ST_FULL) ? 2'd2 : ((st_q == ST_BUSY) ? 2'd1 : 2'd0);
`endif

endmodule

// File: rtl/pipe_reg_elastic.sv
// DEPTH chained skid stages between pipeline stages; stalls become backpressure.
// Defining PIPE_REG_STATS_EN adds occ_o and a saturating stall_cnt_o.
module pipe_reg_elastic
  import pipe_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
`ifdef PIPE_REG_STATS_EN
  output logic [occ_width(DEPTH)-1:0] occ_o,
  output logic [31:0]                 stall_cnt_o,
`endif
  pipe_reg_elastic_if.slave           bus
);

  // Index k is the input of stage k; index DEPTH is the chain output.
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0]            rdy_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;

  assign vld_pipe[0]     = bus.in_valid_i;
  assign dat_pipe[0]     = bus.in_data_i;
  assign bus.in_ready_o  = rdy_pipe[0];
  assign rdy_pipe[DEPTH] = bus.out_ready_i;
  assign bus.out_valid_o = vld_pipe[DEPTH];
  assign bus.out_data_o  = dat_pipe[DEPTH];

`ifdef PIPE_REG_STATS_EN
  localparam int OCCW = occ_width(DEPTH);
  logic [DEPTH-1:0][1:0] st_occ;
  logic [31:0]           stall_cnt_q;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (bus.flush_i),
`ifdef PIPE_REG_STATS_EN
      .occ_o       (st_occ[k]),
`endif
      .in_valid_i  (vld_pipe[k]),
      .in_ready_o  (rdy_pipe[k]),
      .in_data_i   (dat_pipe[k]),
      .out_valid_o (vld_pipe[k+1]),
      .out_ready_i (rdy_pipe[k+1]),
      .out_data_o  (dat_pipe[k+1])
    );
  end

`ifdef PIPE_REG_STATS_EN
  always_comb begin
    occ_o = '0;
    for (int k = 0; k < DEPTH; k++) occ_o = occ_o + OCCW'(st_occ[k]);
  end

  // Counts stalled output cycles; flush deliberately leaves the count intact.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_q <= '0;
    else if (vld_pipe[DEPTH] && !bus.out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
